// File: rtl/nor_chain_sweep_ctrl.sv
// nor_chain_sweep_ctrl: steps vectors 0..LAST_VEC into a cascaded NOR chain,
// waits SETTLE_CYCLES per vector, captures {g,f,e} and streams each result
// over a valid/ready handshake. All outputs are registered.
// Optional build macro: NOR_SWEEP_SELFCHECK_EN enables the internal golden
// model, res_err and the saturating err_cnt; otherwise both are tied to 0.
module nor_chain_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned LAST_VEC      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [3:0] nor_in,
  input  logic [2:0] nor_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_vec,
  output logic [2:0] res_efg,
  output logic       res_err,
  output logic [4:0] err_cnt
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST        = 4'(LAST_VEC);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT} state_e;

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] nor_in_q, nor_in_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       res_valid_q, res_valid_d;
  logic [3:0] res_vec_q, res_vec_d;
  logic [2:0] res_efg_q, res_efg_d;

`ifdef NOR_SWEEP_SELFCHECK_EN
  logic       res_err_q, res_err_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic       gold_e, gold_f, gold_g;
  logic [2:0] golden;

  // Golden chain from the current vector: a=vec[0], b=vec[1], c=vec[2], d=vec[3]
  always_comb begin
    gold_e = ~(vec_q[0] | vec_q[1]);
    gold_f = ~(vec_q[2] | gold_e);
    gold_g = ~(vec_q[3] | gold_f);
    golden = {gold_g, gold_f, gold_e};
  end
`endif

  // Next-state and registered-output logic; abort takes priority over a handshake
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    nor_in_d    = nor_in_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_valid_d = res_valid_q;
    res_vec_d   = res_vec_q;
    res_efg_d   = res_efg_q;
`ifdef NOR_SWEEP_SELFCHECK_EN
    res_err_d   = res_err_q;
    err_cnt_d   = err_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = DRIVE;
          vec_d    = '0;
          nor_in_d = '0;
          busy_d   = 1'b1;
          cnt_d    = SETTLE_LOAD;
`ifdef NOR_SWEEP_SELFCHECK_EN
          err_cnt_d = '0;
`endif
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          nor_in_d    = '0;
        end else if (cnt_q == '0) begin
          state_d     = EMIT;
          res_valid_d = 1'b1;
          res_vec_d   = vec_q;
          res_efg_d   = nor_out;
`ifdef NOR_SWEEP_SELFCHECK_EN
          res_err_d = (nor_out != golden);
          if ((nor_out != golden) && (err_cnt_q != 5'd31)) begin
            err_cnt_d = err_cnt_q + 5'd1;
          end
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          nor_in_d    = '0;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          if (vec_q == LAST) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            nor_in_d = '0;
          end else begin
            state_d  = DRIVE;
            vec_d    = vec_q + 4'd1;
            nor_in_d = vec_q + 4'd1;
            cnt_d    = SETTLE_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      nor_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_vec_q   <= '0;
      res_efg_q   <= '0;
`ifdef NOR_SWEEP_SELFCHECK_EN
      res_err_q   <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      nor_in_q    <= nor_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_vec_q   <= res_vec_d;
      res_efg_q   <= res_efg_d;
`ifdef NOR_SWEEP_SELFCHECK_EN
      res_err_q   <= res_err_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign nor_in    = nor_in_q;
  assign res_valid = res_valid_q;
  assign res_vec   = res_vec_q;
  assign res_efg   = res_efg_q;
`ifdef NOR_SWEEP_SELFCHECK_EN
  assign res_err   = res_err_q;
  assign err_cnt   = err_cnt_q;
`else
  assign res_err   = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_nor_chain_sweep_ctrl.sv
// Bench for nor_chain_sweep_ctrl: scoreboard of expected results checked by a
// handshake monitor, plus directed timing/abort/reset checks.
module tb_nor_chain_sweep_ctrl;

`ifdef NOR_SWEEP_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: S=1, LAST=15
  logic       rst, start, abort, res_ready, force_zero;
  logic       busy, done, res_valid, res_err;
  logic [3:0] nor_in, res_vec;
  logic [2:0] nor_out, res_efg;
  logic [4:0] err_cnt;

  // second instance: S=3, LAST=3
  logic       rst6, start6, abort6, ready6;
  logic       busy6, done6, res_valid6, res_err6;
  logic [3:0] nor_in6, res_vec6;
  logic [2:0] nor_out6, res_efg6;
  logic [4:0] err_cnt6;

  function automatic logic [2:0] chain(input logic [3:0] v);
    logic e, f, g;
    e = ~(v[0] | v[1]);
    f = ~(v[2] | e);
    g = ~(v[3] | f);
    return {g, f, e};
  endfunction

  assign nor_out  = force_zero ? 3'b000 : chain(nor_in);
  assign nor_out6 = chain(nor_in6);

  nor_chain_sweep_ctrl #(.SETTLE_CYCLES(1), .LAST_VEC(15)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .nor_in(nor_in), .nor_out(nor_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_vec(res_vec), .res_efg(res_efg), .res_err(res_err), .err_cnt(err_cnt));

  nor_chain_sweep_ctrl #(.SETTLE_CYCLES(3), .LAST_VEC(3)) dut6 (
    .clk(clk), .rst(rst6), .start(start6), .abort(abort6), .busy(busy6), .done(done6),
    .nor_in(nor_in6), .nor_out(nor_out6), .res_valid(res_valid6), .res_ready(ready6),
    .res_vec(res_vec6), .res_efg(res_efg6), .res_err(res_err6), .err_cnt(err_cnt6));

  // hand-computed {g,f,e} for vec 0..15 with a=vec[0], b=vec[1], c=vec[2], d=vec[3]
  logic [2:0] exp_efg [16] = '{3'b101, 3'b010, 3'b010, 3'b010,
                               3'b101, 3'b100, 3'b100, 3'b100,
                               3'b001, 3'b010, 3'b010, 3'b010,
                               3'b001, 3'b000, 3'b000, 3'b000};

  typedef struct packed {
    logic [3:0] vec;
    logic [2:0] efg;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // zero=1: chain output forced to 000, which only matches golden for vec 13..15
  task automatic push_range(input int unsigned lo, input int unsigned hi, input bit zero);
    exp_t e;
    for (int unsigned v = lo; v <= hi; v++) begin
      e.vec = 4'(v);
      e.efg = zero ? 3'b000 : exp_efg[v];
      e.err = SC && zero && (v < 13);
      sbq.push_back(e);
    end
  endtask

  // start accepted at the first posedge of this task (edge T); returns at T+#1
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // counts edges after T until done is seen high
  task automatic wait_done(output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 300);
    check("done_seen", 32'(done), 32'd1);
  endtask

  // hands off results with single-cycle ready pulses until res_vec==stop is presented
  task automatic accept_until(input logic [3:0] stop);
    int unsigned cnt;
    cnt = 0;
    while (!(res_valid && res_vec == stop) && cnt < 300) begin
      if (res_valid) begin
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
      end else begin
        tick();
      end
      cnt++;
    end
    check("reach_valid", 32'(res_valid), 32'd1);
    check("reach_vec", 32'(res_vec), 32'(stop));
  endtask

  // monitor: every accepted result is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got vec %0d expected no result", res_vec);
      end else begin
        mon_e = sbq.pop_front();
        check("res_vec", 32'(res_vec), 32'(mon_e.vec));
        check("res_efg", 32'(res_efg), 32'(mon_e.efg));
        check("res_err", 32'(res_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; force_zero = 1'b0;
    rst6 = 1'b1; start6 = 1'b0; abort6 = 1'b0; ready6 = 1'b1;
    tick(); tick();
    rst = 1'b0; rst6 = 1'b0;
    tick();

    // reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_nor_in", 32'(nor_in), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_vec", 32'(res_vec), 0);
    check("rst_efg", 32'(res_efg), 0);
    check("rst_err", 32'(res_err), 0);
    check("rst_errcnt", 32'(err_cnt), 0);

    // 1: full sweep with ready tied high
    push_range(0, 15, 1'b0);
    res_ready = 1'b1;
    do_start();
    check("t1_busy", 32'(busy), 1);
    wait_done(n);
    check("t1_done_edge", n, 32);
    check("t1_nor_in_done", 32'(nor_in), 0);
    check("t1_busy_done", 32'(busy), 0);
    tick();
    check("t1_done_pulse", 32'(done), 0);
    check("t1_busy_after", 32'(busy), 0);

    // 2: backpressure on vec 3
    res_ready = 1'b0;
    push_range(0, 15, 1'b0);
    do_start();
    accept_until(4'd3);
    for (int i = 0; i < 5; i++) begin
      check("t2_valid", 32'(res_valid), 1);
      check("t2_vec", 32'(res_vec), 3);
      check("t2_efg", 32'(res_efg), 32'(3'b010));
      check("t2_nor_in", 32'(nor_in), 3);
      tick();
    end
    res_ready = 1'b1;
    wait_done(n);
    tick();

    // 3: abort while presenting vec 7, then a fresh sweep from vec 0
    res_ready = 1'b0;
    push_range(0, 6, 1'b0);
    do_start();
    accept_until(4'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_valid", 32'(res_valid), 0);
    check("t3_busy", 32'(busy), 0);
    check("t3_nor_in", 32'(nor_in), 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_no_done", 32'(done), 0);
      tick();
    end
    push_range(0, 15, 1'b0);
    res_ready = 1'b1;
    do_start();
    wait_done(n);
    check("t3_done_edge", n, 32);
    tick();

    // 4: start pulses while busy are ignored; start+abort in IDLE does nothing
    push_range(0, 15, 1'b0);
    do_start();
    n = 0;
    do begin
      start = ((n % 5) == 2);
      tick();
      n++;
    end while (!done && n < 300);
    start = 1'b0;
    check("t4_done_edge", n, 32);
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t4_busy", 32'(busy), 0);
    tick();
    check("t4_busy2", 32'(busy), 0);
    check("t4_valid", 32'(res_valid), 0);

    // 5: chain forced to 000
    force_zero = 1'b1;
    push_range(0, 15, 1'b1);
    do_start();
    wait_done(n);
    check("t5_err_cnt", 32'(err_cnt), SC ? 32'd13 : 32'd0);
    tick();
    res_ready = 1'b0;
    do_start();
    check("t5_err_clr", 32'(err_cnt), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    force_zero = 1'b0;
    check("t5_abort_busy", 32'(busy), 0);
    check("sb_empty", 32'(sbq.size()), 0);

    // 6: S=3, LAST=3 instance, asynchronous reset in the middle of vec 2 drive
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    repeat (9) tick();
    check("t6_pre_nor_in", 32'(nor_in6), 2);
    check("t6_pre_busy", 32'(busy6), 1);
    #2 rst6 = 1'b1;
    #1;
    check("t6_nor_in", 32'(nor_in6), 0);
    check("t6_busy", 32'(busy6), 0);
    check("t6_done", 32'(done6), 0);
    check("t6_valid", 32'(res_valid6), 0);
    check("t6_vec", 32'(res_vec6), 0);
    check("t6_efg", 32'(res_efg6), 0);
    check("t6_err", 32'(res_err6), 0);
    check("t6_errcnt", 32'(err_cnt6), 0);
    tick();
    rst6 = 1'b0;
    tick();
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    tick(); tick();
    check("t6_valid_T2", 32'(res_valid6), 0);
    tick();
    check("t6_valid_T3", 32'(res_valid6), 1);
    check("t6_vec_T3", 32'(res_vec6), 0);
    check("t6_efg_T3", 32'(res_efg6), 32'(3'b101));
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
